// File: rtl/rgb_pwm_sequencer_pkg.sv
// Shared definitions for the RGB PWM sequencer: mode encoding and default geometry.
package rgb_pwm_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_PRESC_BITS = 20;

endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// Configuration inputs and PWM/envelope outputs of the RGB PWM sequencer.
interface rgb_pwm_sequencer_if #(
  parameter int NUM_CH     = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 20
);
  logic [1:0]                 mode_i;
  logic [NUM_CH*PWM_BITS-1:0] duty_i;
  logic [PRESC_BITS-1:0]      presc_div_i;
  logic [NUM_CH-1:0]          pwm_o;
  logic [PWM_BITS-1:0]        env_o;
  logic                       tick_o;
  logic                       period_o;

  modport master (
    output mode_i, duty_i, presc_div_i,
    input  pwm_o, env_o, tick_o, period_o
  );

  modport slave (
    input  mode_i, duty_i, presc_div_i,
    output pwm_o, env_o, tick_o, period_o
  );
endinterface

// File: rtl/rgb_pwm_sequencer_env_gen.sv
// Envelope generator: rate prescaler, tick strobe and the off/solid/blink/breathe
// envelope state machine. A mode change restarts the prescaler and the envelope.
module rgb_env_gen
  import rgb_pwm_sequencer_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int PRESC_BITS = DEF_PRESC_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode_i,
  input  logic [PRESC_BITS-1:0] presc_div_i,
  output mode_e                 mode_o,
  output logic [PWM_BITS-1:0]   env_o,
  output logic                  tick_o
);

  localparam logic [PWM_BITS-1:0] ENV_MAX    = '1;
  localparam logic [PWM_BITS-1:0] ENV_MAX_M1 = ENV_MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] ENV_ONE    = PWM_BITS'(1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  mode_e                 mode_q, mode_d;
  dir_e                  dir_q, dir_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [PWM_BITS-1:0]   env_q, env_d;
  logic                  tick_q, tick_d;
  logic                  mode_chg;
  logic                  presc_hit;

  // Counter only resets on an exact match, so lowering the divider below the
  // current count lets it run through all-ones and wrap rather than lock up.
  always_comb begin
    mode_d    = mode_e'(mode_i);
    mode_chg  = (mode_d != mode_q);
    presc_hit = (presc_q == presc_div_i);
    presc_d   = presc_q + PRESC_BITS'(1);
    tick_d    = 1'b0;
    env_d     = env_q;
    dir_d     = dir_q;
    if (mode_chg) begin
      presc_d = '0;
      env_d   = '0;
      dir_d   = DIR_UP;
    end else if (presc_hit) begin
      presc_d = '0;
      tick_d  = 1'b1;
      case (mode_q)
        MODE_BLINK: begin
          env_d = (env_q == '0) ? ENV_MAX : '0;
        end
        MODE_BREATHE: begin
          if (dir_q == DIR_UP) begin
            if (env_q != ENV_MAX) env_d = env_q + ENV_ONE;
            if (env_q >= ENV_MAX_M1) dir_d = DIR_DOWN;
          end else begin
            if (env_q != '0) env_d = env_q - ENV_ONE;
            if (env_q <= ENV_ONE) dir_d = DIR_UP;
          end
        end
        default: begin
          env_d = '0;
          dir_d = DIR_UP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      presc_q <= '0;
      env_q   <= '0;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      env_q   <= env_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
    end
  end

  assign mode_o = mode_q;
  assign env_o  = env_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel PWM/pattern generator feeding the RGBxPWM pins of SB_RGBA_DRV.
// Effective duties are latched on the last count of a period so edges never glitch.
module rgb_pwm_sequencer
  import rgb_pwm_sequencer_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int PRESC_BITS = DEF_PRESC_BITS
) (
  input  logic               int_osc,
  input  logic               rst_n,
  rgb_pwm_sequencer_if.slave bus
);

  localparam int                  PROD_BITS = 2*PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;

  mode_e               mode;
  logic [PWM_BITS-1:0] env;
  logic                tick;

  rgb_env_gen #(
    .PWM_BITS   (PWM_BITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_env_gen (
    .clk         (int_osc),
    .rst_n       (rst_n),
    .mode_i      (bus.mode_i),
    .presc_div_i (bus.presc_div_i),
    .mode_o      (mode),
    .env_o       (env),
    .tick_o      (tick)
  );

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                period_q, period_d;
  logic                cnt_wrap;
  logic [NUM_CH-1:0]   pwm_vec;

  always_comb begin
    cnt_wrap  = (pwm_cnt_q == CNT_MAX);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    period_d  = cnt_wrap;
  end

  always_ff @(posedge int_osc or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      period_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      period_q  <= period_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PWM_BITS-1:0]  duty;
    logic [PWM_BITS:0]    env_p1;
    logic [PROD_BITS-1:0] prod;
    logic [PWM_BITS-1:0]  scaled;
    logic [PWM_BITS-1:0]  eff_q, eff_d;
    logic                 pwm_q, pwm_d;

    assign duty = bus.duty_i[k*PWM_BITS +: PWM_BITS];

    // Scaling by env+1 makes a full envelope reproduce the programmed duty exactly.
    always_comb begin
      env_p1 = {1'b0, env} + (PWM_BITS+1)'(1);
      prod   = PROD_BITS'(duty) * PROD_BITS'(env_p1);
      scaled = PWM_BITS'(prod >> PWM_BITS);
      eff_d  = eff_q;
      if (cnt_wrap) begin
        case (mode)
          MODE_OFF:   eff_d = '0;
          MODE_SOLID: eff_d = duty;
          default:    eff_d = scaled;
        endcase
      end
      pwm_d = (pwm_cnt_q < eff_q);
    end

    always_ff @(posedge int_osc or negedge rst_n) begin
      if (!rst_n) begin
        eff_q <= '0;
        pwm_q <= 1'b0;
      end else begin
        eff_q <= eff_d;
        pwm_q <= pwm_d;
      end
    end

    assign pwm_vec[k] = pwm_q;
  end

  assign bus.pwm_o    = pwm_vec;
  assign bus.env_o    = env;
  assign bus.tick_o   = tick;
  assign bus.period_o = period_q;

endmodule
